// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/edge-select registers, lowest-index
// arbitration, and a one-cycle pulse to the core. Define IRQ_SYNC_EN to add 2-flop src synchronizers.
module irq_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic [NUM_SRC-1:0] src,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  output logic [31:0]        bus_rdata,
  output logic               irq_out,
  output logic [4:0]         claim_id
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SERVICE} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] set_vec, clr_vec, active;
  logic [31:0]        rdata_q, rdata_d, reg_rd;
  logic               irq_q;
  logic [4:0]         claim_q, winner;
  logic               hit, wr, complete;
  logic [1:0]         off;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end
  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  assign hit    = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off    = bus_addr[3:2];
  assign wr     = hit && bus_we;
  assign active = pending_q & mask_q;

  // Edge mode needs the previous sample low; level mode sets whenever src is high.
  assign set_vec  = src_s & (~edge_sel_q | ~src_prev_q);
  assign complete = wr && (off == 2'd3) && (state_q == S_SERVICE) &&
                    (bus_wdata[4:0] == claim_q + 5'd1);

  always_comb begin
    clr_vec = '0;
    if (wr && off == 2'd0) clr_vec = bus_wdata[NUM_SRC-1:0];
    if (complete)          clr_vec = clr_vec | (NUM_SRC'(1) << claim_q);
  end

  // Set is OR-ed in last so it wins over a same-cycle clear.
  assign pending_d  = (pending_q & ~clr_vec) | set_vec;
  assign mask_d     = (wr && off == 2'd1) ? bus_wdata[NUM_SRC-1:0] : mask_q;
  assign edge_sel_d = (wr && off == 2'd2) ? bus_wdata[NUM_SRC-1:0] : edge_sel_q;

  always_comb begin
    winner = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 5'(i);
    end
  end

  always_comb begin
    reg_rd = 32'd0;
    case (off)
      2'd0: reg_rd = 32'(pending_q);
      2'd1: reg_rd = 32'(mask_q);
      2'd2: reg_rd = 32'(edge_sel_q);
      2'd3: reg_rd = (state_q == S_SERVICE) ? {27'd0, claim_q + 5'd1} : 32'd0;
      default: reg_rd = 32'd0;
    endcase
    rdata_d = hit ? reg_rd : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      src_prev_q <= '0;
      rdata_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      src_prev_q <= src_s;
      rdata_q    <= rdata_d;
    end
  end

  // irq_q is high exactly while the FSM sits in FIRE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      claim_q <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          irq_q <= 1'b0;
          if (ena && |active) begin
            claim_q <= winner;
            irq_q   <= 1'b1;
            state_q <= S_FIRE;
          end
        end
        S_FIRE: begin
          irq_q   <= 1'b0;
          state_q <= S_SERVICE;
        end
        S_SERVICE: begin
          irq_q <= 1'b0;
          if (complete) state_q <= S_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_rdata = rdata_q;
  assign irq_out   = irq_q;
  assign claim_id  = claim_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, arbitration, claim/complete handshake,
// level re-fire, ena gating and asynchronous reset.
module tb_irq_ctrl;

  localparam logic [31:0] BASE  = 32'h1000_0040;
  localparam logic [3:0]  PEND  = 4'h0;
  localparam logic [3:0]  MASK  = 4'h4;
  localparam logic [3:0]  EDGE  = 4'h8;
  localparam logic [3:0]  CLAIM = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [7:0]  src;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we;
  logic        irq_out;
  logic [4:0]  claim_id;

  int checks    = 0;
  int failures  = 0;
  int pulse_cnt = 0;
  logic [31:0] exp_q[$];

  irq_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .src      (src),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_rdata(bus_rdata),
    .irq_out  (irq_out),
    .claim_id (claim_id)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq_out) pulse_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    bus_addr  = BASE + 32'(off);
    bus_wdata = data;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    @(negedge clk);
    bus_addr = BASE + 32'(off);
    bus_we   = 1'b0;
    @(negedge clk);
    data     = bus_rdata;
    bus_addr = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(off, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int base_pulses;

    reset = 1'b0; ena = 1'b1; src = 8'h00;
    bus_addr = 32'd0; bus_wdata = 32'd0; bus_we = 1'b0;
    wait_cycles(3);
    check("reset_irq", 32'(irq_out), 32'd0);
    check("reset_claim_id", 32'(claim_id), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    reset = 1'b1;

    // 1: all registers read zero after reset
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), d);
      check($sformatf("reset_reg_%0d", i), d, exp_q.pop_front());
    end
    check("reset_no_pulse", 32'(pulse_cnt), 32'd0);

    // 2: single edge source
    bus_write(MASK, 32'h04);
    bus_write(EDGE, 32'h04);
    src = 8'h04;
    wait_cycles(6);
    check("t2_pulses", 32'(pulse_cnt), 32'd1);
    check("t2_claim_id", 32'(claim_id), 32'd2);
    read_check("t2_pending", PEND, 32'h04);
    read_check("t2_claim_rd", CLAIM, 32'd3);
    bus_write(CLAIM, 32'd3);
    read_check("t2_pending_clr", PEND, 32'h00);
    read_check("t2_claim_idle", CLAIM, 32'd0);
    wait_cycles(4);
    check("t2_single_pulse", 32'(pulse_cnt), 32'd1);
    src = 8'h00;

    // W1C and set-wins with interrupts masked off
    bus_write(MASK, 32'h00);
    bus_write(EDGE, 32'h00);
    src = 8'h08;
    @(negedge clk);
    src = 8'h00;
    wait_cycles(4);
    read_check("w1c_latched", PEND, 32'h08);
    src = 8'h08;
    bus_write(PEND, 32'h08);
    read_check("w1c_set_wins", PEND, 32'h08);
    src = 8'h00;
    wait_cycles(4);
    bus_write(PEND, 32'h08);
    read_check("w1c_cleared", PEND, 32'h00);
    bus_write(MASK, 32'h100);
    read_check("mask_upper_bits", MASK, 32'h00);
    check("masked_no_pulse", 32'(pulse_cnt), 32'd1);

    // 3/4: simultaneous edges, lowest index first, mismatched complete ignored
    bus_write(EDGE, 32'hFF);
    bus_write(MASK, 32'hFF);
    src = 8'h22;
    wait_cycles(6);
    check("t3_pulses", 32'(pulse_cnt), 32'd2);
    check("t3_claim_first", 32'(claim_id), 32'd1);
    read_check("t3_pending", PEND, 32'h22);
    bus_write(CLAIM, 32'd4);
    wait_cycles(3);
    read_check("t4_claim_rd", CLAIM, 32'd2);
    check("t4_claim_id", 32'(claim_id), 32'd1);
    check("t4_no_pulse", 32'(pulse_cnt), 32'd2);
    bus_write(CLAIM, 32'd2);
    wait_cycles(6);
    check("t3_second_pulse", 32'(pulse_cnt), 32'd3);
    check("t3_claim_second", 32'(claim_id), 32'd5);
    read_check("t3_pending_rem", PEND, 32'h20);
    bus_write(CLAIM, 32'd6);
    read_check("t3_pending_empty", PEND, 32'h00);
    src = 8'h00;

    // 5: level source re-fires after complete; ena gates the pulse
    bus_write(MASK, 32'h01);
    bus_write(EDGE, 32'h00);
    src = 8'h01;
    wait_cycles(6);
    check("t5_pulse", 32'(pulse_cnt), 32'd4);
    check("t5_claim_id", 32'(claim_id), 32'd0);
    bus_write(CLAIM, 32'd1);
    check("t5_idle_no_irq", 32'(irq_out), 32'd0);
    @(negedge clk);
    check("t5_refire", 32'(irq_out), 32'd1);
    wait_cycles(2);
    read_check("t5_pending_kept", PEND, 32'h01);
    read_check("t5_claim_rd", CLAIM, 32'd1);
    ena = 1'b0;
    base_pulses = pulse_cnt;
    bus_write(CLAIM, 32'd1);
    wait_cycles(5);
    check("t5_ena_blocks", 32'(pulse_cnt), 32'(base_pulses));
    read_check("t5_ena_pending", PEND, 32'h01);
    read_check("t5_ena_idle", CLAIM, 32'd0);
    ena = 1'b1;
    wait_cycles(3);
    check("t5_ena_release", 32'(pulse_cnt), 32'(base_pulses + 1));

    // 6: asynchronous reset in SERVICE with everything pending
    bus_write(MASK, 32'hFF);
    src = 8'hFE;
    bus_write(CLAIM, 32'd1);
    wait_cycles(6);
    check("t6_claim_id", 32'(claim_id), 32'd1);
    src = 8'hFF;
    wait_cycles(4);
    read_check("t6_pending_all", PEND, 32'hFF);
    @(negedge clk);
    bus_addr = BASE + 32'(CLAIM);
    @(posedge clk);
    #2;
    check("t6_pre_rdata", bus_rdata, 32'd2);
    reset = 1'b0;
    #1;
    check("t6_async_rdata", bus_rdata, 32'd0);
    check("t6_async_claim", 32'(claim_id), 32'd0);
    check("t6_async_irq", 32'(irq_out), 32'd0);
    src = 8'h00;
    bus_addr = 32'd0;
    base_pulses = pulse_cnt;
    wait_cycles(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), d);
      check($sformatf("t6_reg_%0d", i), d, 32'd0);
    end
    wait_cycles(3);
    check("t6_no_pulse", 32'(pulse_cnt), 32'(base_pulses));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
